// File: rtl/mem_stage.sv
// Memory pipeline stage: passes non-memory instructions straight to MEM/WB and
// runs a two-state handshake with data memory, aborting with a sticky error on timeout.
module mem_stage #(
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_res,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_op_dest,
  input  logic        ex_mem_write_en,
  input  logic        ex_wb_mux,
  input  logic        ex_wb_en,
  input  logic [3:0]  opcode_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [15:0] mem_wb_alu_res,
  output logic [15:0] mem_wb_read_data,
  output logic [2:0]  mem_wb_op_dest,
  output logic        mem_wb_wb_mux,
  output logic        mem_wb_wb_en,
  output logic [3:0]  opcode_mem_wb,
  output logic        mem_stall,
  output logic [15:0] frwd_res_mem,
  output logic        mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [7:0] busy_cnt;
  logic [2:0] lat_dest;
  logic       lat_wb_mux;
  logic       lat_wb_en;
  logic [3:0] lat_opcode;
  logic       access;
  logic       timeout_hit;

  assign access      = ex_mem_write_en | ex_wb_mux;
  // busy_cnt holds the number of BUSY cycles already spent before the current one
  assign timeout_hit = (state == BUSY) && !dmem_ready &&
                       (busy_cnt == 8'(DMEM_TIMEOUT - 1));

  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      if (state == IDLE) mem_stall = access;
      else               mem_stall = !dmem_ready && !timeout_hit;
    end
  end

  assign frwd_res_mem = mem_wb_wb_mux ? mem_wb_read_data : mem_wb_alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy_cnt         <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      lat_dest         <= '0;
      lat_wb_mux       <= 1'b0;
      lat_wb_en        <= 1'b0;
      lat_opcode       <= '0;
      mem_wb_alu_res   <= '0;
      mem_wb_read_data <= '0;
      mem_wb_op_dest   <= '0;
      mem_wb_wb_mux    <= 1'b0;
      mem_wb_wb_en     <= 1'b0;
      opcode_mem_wb    <= '0;
      mem_err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state            <= BUSY;
            busy_cnt         <= '0;
            dmem_req         <= 1'b1;
            dmem_we          <= ex_mem_write_en;
            dmem_addr        <= alu_res;
            dmem_wdata       <= ex_store_data;
            lat_dest         <= ex_op_dest;
            lat_wb_mux       <= ex_wb_mux;
            lat_wb_en        <= ex_wb_en;
            lat_opcode       <= opcode_ex_mem;
            mem_wb_alu_res   <= '0;
            mem_wb_read_data <= '0;
            mem_wb_op_dest   <= '0;
            mem_wb_wb_mux    <= 1'b0;
            mem_wb_wb_en     <= 1'b0;
            opcode_mem_wb    <= '0;
          end else begin
            mem_wb_alu_res   <= alu_res;
            mem_wb_read_data <= '0;
            mem_wb_op_dest   <= ex_op_dest;
            mem_wb_wb_mux    <= ex_wb_mux;
            mem_wb_wb_en     <= ex_wb_en;
            opcode_mem_wb    <= opcode_ex_mem;
          end
        end
        BUSY: begin
          if (dmem_ready || timeout_hit) begin
            // an abort keeps the latched control but never writes back
            state            <= IDLE;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            mem_wb_alu_res   <= dmem_addr;
            mem_wb_read_data <= (dmem_ready && lat_wb_mux) ? dmem_rdata : 16'h0000;
            mem_wb_op_dest   <= lat_dest;
            mem_wb_wb_mux    <= lat_wb_mux;
            mem_wb_wb_en     <= dmem_ready ? lat_wb_en : 1'b0;
            opcode_mem_wb    <= lat_opcode;
            if (!dmem_ready) mem_err <= 1'b1;
          end else begin
            busy_cnt         <= busy_cnt + 8'd1;
            mem_wb_alu_res   <= '0;
            mem_wb_read_data <= '0;
            mem_wb_op_dest   <= '0;
            mem_wb_wb_mux    <= 1'b0;
            mem_wb_wb_en     <= 1'b0;
            opcode_mem_wb    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// streams checked against a transaction-level model of stall, handshake and writeback.
module tb_mem_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_res, ex_store_data;
  logic [2:0]  ex_op_dest;
  logic        ex_mem_write_en, ex_wb_mux, ex_wb_en;
  logic [3:0]  opcode_ex_mem;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic [15:0] mem_wb_alu_res, mem_wb_read_data;
  logic [2:0]  mem_wb_op_dest;
  logic        mem_wb_wb_mux, mem_wb_wb_en;
  logic [3:0]  opcode_mem_wb;
  logic        mem_stall;
  logic [15:0] frwd_res_mem;
  logic        mem_err;

  int   testCount = 0;
  int   failCount = 0;
  logic errModel  = 1'b0;

  mem_stage #(.DMEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .alu_res(alu_res), .ex_store_data(ex_store_data), .ex_op_dest(ex_op_dest),
    .ex_mem_write_en(ex_mem_write_en), .ex_wb_mux(ex_wb_mux), .ex_wb_en(ex_wb_en),
    .opcode_ex_mem(opcode_ex_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_wb_alu_res(mem_wb_alu_res), .mem_wb_read_data(mem_wb_read_data),
    .mem_wb_op_dest(mem_wb_op_dest), .mem_wb_wb_mux(mem_wb_wb_mux),
    .mem_wb_wb_en(mem_wb_wb_en), .opcode_mem_wb(opcode_mem_wb),
    .mem_stall(mem_stall), .frwd_res_mem(frwd_res_mem), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic wbmux, input logic wben,
                               input logic [2:0] dest, input logic [3:0] op,
                               input logic [15:0] alu, input logic [15:0] sdata);
    ex_mem_write_en = we;
    ex_wb_mux       = wbmux;
    ex_wb_en        = wben;
    ex_op_dest      = dest;
    opcode_ex_mem   = op;
    alu_res         = alu;
    ex_store_data   = sdata;
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that retires the instruction.
  // readyDelay = number of BUSY cycles memory keeps dmem_ready low before raising it.
  task automatic runInstr(input logic we, input logic wbmux, input logic wben,
                          input logic [2:0] dest, input logic [3:0] op,
                          input logic [15:0] alu, input logic [15:0] sdata,
                          input int readyDelay, input logic [15:0] rdata);
    logic done;
    logic rdy;
    done = 1'b0;
    rdy  = 1'b0;
    applyStimulus(we, wbmux, wben, dest, op, alu, sdata);
    dmem_ready = 1'($urandom);
    dmem_rdata = 16'($urandom);
    #1;
    if (!(we | wbmux)) begin
      checkOutput("pt_stall", mem_stall, 0);
      @(posedge clk); #1;
      checkOutput("pt_alu", mem_wb_alu_res, alu);
      checkOutput("pt_rdata", mem_wb_read_data, 0);
      checkOutput("pt_dest", mem_wb_op_dest, dest);
      checkOutput("pt_wbmux", mem_wb_wb_mux, 0);
      checkOutput("pt_wben", mem_wb_wb_en, wben);
      checkOutput("pt_opcode", opcode_mem_wb, op);
      checkOutput("pt_frwd", frwd_res_mem, alu);
      checkOutput("pt_req", dmem_req, 0);
      checkOutput("pt_err", mem_err, errModel);
    end else begin
      checkOutput("idle_stall", mem_stall, 1);
      @(posedge clk); #1;
      for (int k = 1; k <= TIMEOUT; k++) begin
        checkOutput("busy_req", dmem_req, 1);
        checkOutput("busy_we", dmem_we, we);
        checkOutput("busy_addr", dmem_addr, alu);
        checkOutput("busy_wdata", dmem_wdata, sdata);
        checkOutput("bubble_wben", mem_wb_wb_en, 0);
        checkOutput("bubble_opcode", opcode_mem_wb, 0);
        checkOutput("bubble_wbmux", mem_wb_wb_mux, 0);
        rdy = (k == readyDelay + 1);
        dmem_ready = rdy;
        dmem_rdata = rdy ? rdata : 16'($urandom);
        #1;
        done = rdy || (k == TIMEOUT);
        checkOutput("busy_stall", mem_stall, !done);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        if (done) break;
      end
      checkOutput("done_req", dmem_req, 0);
      checkOutput("done_we", dmem_we, 0);
      if (rdy) begin
        checkOutput("cmp_alu", mem_wb_alu_res, alu);
        checkOutput("cmp_rdata", mem_wb_read_data, wbmux ? rdata : 16'h0000);
        checkOutput("cmp_dest", mem_wb_op_dest, dest);
        checkOutput("cmp_wbmux", mem_wb_wb_mux, wbmux);
        checkOutput("cmp_wben", mem_wb_wb_en, wben);
        checkOutput("cmp_opcode", opcode_mem_wb, op);
        checkOutput("cmp_frwd", frwd_res_mem, wbmux ? rdata : alu);
      end else begin
        errModel = 1'b1;
        checkOutput("abort_wben", mem_wb_wb_en, 0);
        checkOutput("abort_rdata", mem_wb_read_data, 0);
      end
      checkOutput("done_err", mem_err, errModel);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 16'h0, 16'h0);
    dmem_ready = 1'b0;
    dmem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_stall", mem_stall, 0);
    checkOutput("rst_err", mem_err, 0);
    checkOutput("rst_wben", mem_wb_wb_en, 0);
    checkOutput("rst_opcode", opcode_mem_wb, 0);
    rst = 1'b0;

    // pass-through, load with immediate ready, store with delayed ready
    runInstr(1'b0, 1'b0, 1'b1, 3'd5, 4'd3, 16'h0042, 16'h0000, 0, 16'h0000);
    runInstr(1'b0, 1'b1, 1'b1, 3'd2, 4'd5, 16'h0010, 16'h0000, 0, 16'hBEEF);
    runInstr(1'b1, 1'b0, 1'b0, 3'd0, 4'd6, 16'h0020, 16'h1234, 3, 16'h0000);

    // random instruction stream; delays past the timeout exercise aborts
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 0)
        runInstr(1'b0, 1'b0, 1'($urandom), 3'($urandom), 4'($urandom),
                 16'($urandom), 16'($urandom), 0, 16'h0);
      else
        runInstr(kind == 2, kind == 1, 1'($urandom), 3'($urandom), 4'($urandom),
                 16'($urandom), 16'($urandom), int'($urandom_range(0, 17)), 16'($urandom));
    end

    // explicit timeout, then the error must stay sticky
    runInstr(1'b0, 1'b1, 1'b1, 3'd1, 4'd7, 16'h0030, 16'h0000, 1000, 16'h0);
    checkOutput("timeout_err", mem_err, 1);
    runInstr(1'b0, 1'b0, 1'b1, 3'd4, 4'd2, 16'h0050, 16'h0000, 0, 16'h0);
    checkOutput("sticky_err", mem_err, 1);

    // reset on the second BUSY cycle of a load
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 4'd9, 16'h0060, 16'h0000);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_busy_req", dmem_req, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 16'h0, 16'h0);
    #1;
    checkOutput("mid_rst_stall", mem_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    errModel = 1'b0;
    checkOutput("mid_req", dmem_req, 0);
    checkOutput("mid_we", dmem_we, 0);
    checkOutput("mid_addr", dmem_addr, 0);
    checkOutput("mid_wdata", dmem_wdata, 0);
    checkOutput("mid_alu", mem_wb_alu_res, 0);
    checkOutput("mid_wben", mem_wb_wb_en, 0);
    checkOutput("mid_opcode", opcode_mem_wb, 0);
    checkOutput("mid_err", mem_err, 0);
    dmem_ready = 1'b1;
    dmem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checkOutput("late_rdy_wben", mem_wb_wb_en, 0);
      checkOutput("late_rdy_rdata", mem_wb_read_data, 0);
      checkOutput("late_rdy_opcode", opcode_mem_wb, 0);
      checkOutput("late_rdy_req", dmem_req, 0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DMEM_TIMEOUT, default 15; the maximum number of BUSY cycles to wait for dmem_ready before aborting (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have inputs from the EX/MEM register:
- alu_res, 16 bits
- ex_store_data, 16 bits
- ex_op_dest, 3 bits
- ex_mem_write_en, 1 bit
- ex_wb_mux, 1 bit (1 = load; write back memory data)
- ex_wb_en, 1 bit
- opcode_ex_mem, 4 bits
REQ-005 SHALL have data-memory port signals:
- dmem_req, output, 1 bit
- dmem_we, output, 1 bit
- dmem_addr, output, 16 bits
- dmem_wdata, output, 16 bits
- dmem_rdata, input, 16 bits
- dmem_ready, input, 1 bit
REQ-006 SHALL have outputs to the MEM/WB register:
- mem_wb_alu_res, 16 bits
- mem_wb_read_data, 16 bits
- mem_wb_op_dest, 3 bits
- mem_wb_wb_mux, 1 bit
- mem_wb_wb_en, 1 bit
- opcode_mem_wb, 4 bits
REQ-007 SHALL have output mem_stall, 1 bit, combinational; when high, upstream stages hold and the EX/MEM register keeps its contents.
REQ-008 SHALL have output frwd_res_mem, 16 bits, combinational; equals mem_wb_read_data when mem_wb_wb_mux=1, otherwise mem_wb_alu_res.
REQ-009 SHALL have output mem_err, 1 bit; sticky flag set on a timeout.

Function
REQ-010 An access SHALL be defined as ex_mem_write_en=1 or ex_wb_mux=1; every other instruction is a pass-through.
REQ-011 The FSM SHALL have exactly two states, IDLE and BUSY; the reset state is IDLE.
REQ-012 IDLE with an access present SHALL:
- assert mem_stall in the same cycle;
- latch dmem_addr=alu_res, dmem_wdata=ex_store_data, dmem_we=ex_mem_write_en, plus dest, wb_mux, wb_en and opcode;
- set dmem_req=1 and go to BUSY at the next edge.
REQ-013 IDLE with a pass-through SHALL, at the next edge, load the MEM/WB outputs from the EX inputs (mem_wb_read_data=0), giving 1-cycle latency with no stall.
REQ-014 In BUSY, dmem_req and the latched address, data and dmem_we SHALL be held stable until completion.
REQ-015 In BUSY, mem_stall SHALL equal NOT dmem_ready.
REQ-016 BUSY with dmem_ready=1 SHALL, at that edge:
- capture dmem_rdata into mem_wb_read_data (loads only; 0 for stores);
- load the latched control into the MEM/WB outputs;
- drop dmem_req and return to IDLE.
REQ-017 dmem_ready SHALL be ignored in IDLE.
REQ-018 Minimum access latency SHALL be 2 cycles (one stall cycle when dmem_ready is high in the first BUSY cycle).
REQ-019 While mem_stall=1 and no completion occurs, the MEM/WB outputs SHALL carry a bubble: mem_wb_wb_en=0, opcode_mem_wb=0, mem_wb_wb_mux=0.
REQ-020 A BUSY cycle counter SHALL behave as follows:
- it clears on entry to BUSY;
- if it reaches DMEM_TIMEOUT with dmem_ready still 0, the access completes as an abort;
- abort = dmem_req dropped, mem_err set to 1, mem_wb_read_data=0, mem_wb_wb_en forced to 0, return to IDLE, mem_stall=0 in that cycle.
REQ-021 mem_err SHALL be cleared only by rst.
REQ-022 Back-to-back accesses SHALL each pass through IDLE for at least one cycle; a new access never enters BUSY in the cycle of a completion.
REQ-023 dmem_we SHALL be 0 whenever dmem_req=0.

Reset
REQ-024 rst=1 at a clock edge SHALL:
- set the state to IDLE;
- zero every output register: all mem_wb_* outputs, opcode_mem_wb, dmem_req, dmem_we, dmem_addr, dmem_wdata;
- clear mem_err and the timeout counter.
REQ-025 A reset asserted in BUSY SHALL abandon the access; dmem_req is 0 in the cycle after the reset edge, and no MEM/WB update from the abandoned access ever occurs.
REQ-026 While rst=1, mem_stall SHALL be 0.

Verification
REQ-027 Pass-through: opcode 3, alu_res=16'h0042, ex_wb_en=1, ex_op_dest=5 -> next cycle mem_wb_alu_res=16'h0042, mem_wb_wb_en=1, frwd_res_mem=16'h0042, mem_stall never high.
REQ-028 Load with ready held high: alu_res=16'h0010, ex_wb_mux=1, dmem_rdata=16'hBEEF -> mem_stall high 1 cycle, dmem_req for 1 cycle with dmem_addr=16'h0010, then mem_wb_read_data=16'hBEEF, frwd_res_mem=16'hBEEF.
REQ-029 Store with ready delayed 3 cycles: ex_store_data=16'h1234, alu_res=16'h0020 -> dmem_we=1 with dmem_addr and dmem_wdata stable for 4 BUSY cycles, mem_wb_wb_en=0 bubbles during the stall, then IDLE.
REQ-030 Timeout: a load with dmem_ready tied low -> after DMEM_TIMEOUT=15 BUSY cycles, dmem_req=0, mem_err=1, mem_wb_wb_en=0, mem_stall=0; mem_err stays 1 until rst.
REQ-031 Reset mid-access: rst pulsed on the 2nd BUSY cycle -> dmem_req=0 and all outputs 0 the cycle after the reset edge; a later dmem_ready pulse causes no MEM/WB update.
